// File: rtl/multiplicador_param_pkg.sv
// Shared definitions for the parametrised shift-add multiplier.
// Holds the FSM state encoding and the counter-width helper. The future
// divider block is expected to import the same package.
package multiplicador_param_pkg;

    // Controller states. The encodings are fixed so that waveforms and
    // the divider block read the same way.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of a counter that has to reach width-1.
    // The result is clamped to at least 1 bit.
    function automatic int cntWidth(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/multiplicador_param_if.sv
// Bus bundle between a requester and the multiplier.
// Ports (seen from the multiplier / slave side):
//   start          in   request, sampled only while Idle is high
//   sinal          in   1 = signed operation, 0 = unsigned
//   multiplicando  in   operand A, WIDTH bits
//   multiplicador2 in   operand B, WIDTH bits
//   produto        out  result register, 2*WIDTH bits
//   Idle           out  high while the multiplier can accept a start
//   Done           out  one-cycle pulse when produto holds a new result
interface multiplicador_param_if #(
    parameter int WIDTH = 16
);
    import multiplicador_param_pkg::*;

    logic                   start;
    logic                   sinal;
    logic [WIDTH-1:0]       multiplicando;
    logic [WIDTH-1:0]       multiplicador2;
    logic [2*WIDTH-1:0]     produto;
    logic                   Idle;
    logic                   Done;

    modport master (
        output start, sinal, multiplicando, multiplicador2,
        input  produto, Idle, Done
    );

    modport slave (
        input  start, sinal, multiplicando, multiplicador2,
        output produto, Idle, Done
    );

endinterface

// File: rtl/multiplicador_param_datapath.sv
// Arithmetic datapath of the shift-add multiplier (module mult_datapath).
// It forms the operand magnitudes at load and runs one add/shift step per
// cycle on a 2*WIDTH+1 accumulator. It also presents the sign-corrected
// product of the step in progress.
// Ports:
//   clock, rst  clock and synchronous active-low reset
//   load_i      capture operands and sign mode, initialise the accumulator
//   step_i      perform one add/shift step
//   finish_i    last step; result_o is valid and the accumulator is cleared
//   sinal_i     signed mode for the operands presented with load_i
//   opA_i       multiplicand
//   opB_i       multiplier
//   result_o    product of the current step, negated when the signs differ
module mult_datapath
    import multiplicador_param_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 finish_i,
    input  logic                 sinal_i,
    input  logic [WIDTH-1:0]     opA_i,
    input  logic [WIDTH-1:0]     opB_i,
    output logic [2*WIDTH-1:0]   result_o
);

    logic [2*WIDTH:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic                neg_q, neg_d;

    logic [WIDTH-1:0]    magA;
    logic [WIDTH-1:0]    magB;
    logic [WIDTH-1:0]    addend;
    logic [WIDTH:0]      partialSum;
    logic [2*WIDTH-1:0]  stepProduct;

    // Operand magnitudes. The most negative value maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits, so the product is exact.
    always_comb begin
        magA = (sinal_i && opA_i[WIDTH-1]) ? -opA_i : opA_i;
        magB = (sinal_i && opB_i[WIDTH-1]) ? -opB_i : opB_i;
    end

    // One shift-add step. The high half of the accumulator is always
    // below 2^WIDTH before the add, so the carry fits in the extra bit.
    // After the shift the top accumulator bit is zero again.
    // stepProduct is the lower 2*WIDTH bits after the shift.
    always_comb begin
        addend      = acc_q[0] ? mcand_q : '0;
        partialSum  = acc_q[2*WIDTH:WIDTH] + {1'b0, addend};
        stepProduct = {partialSum, acc_q[WIDTH-1:1]};
        result_o    = neg_q ? -stepProduct : stepProduct;
    end

    // Next-state selection.
    // The multiplier magnitude starts in the low half of the accumulator.
    // It is consumed from the LSB as the product shifts in from the top.
    // Clearing on finish leaves nothing stale between operations.
    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        if (load_i) begin
            acc_d   = {{(WIDTH+1){1'b0}}, magB};
            mcand_d = magA;
            neg_d   = sinal_i & (opA_i[WIDTH-1] ^ opB_i[WIDTH-1]);
        end else if (finish_i) begin
            acc_d   = '0;
        end else if (step_i) begin
            acc_d   = {1'b0, stepProduct};
        end
    end

    // Datapath registers with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: rtl/multiplicador_param.sv
// Parametrised sequential shift-add multiplier for the MULT/MULTU path.
// Each operation takes a fixed WIDTH cycles of calculation plus one Done
// cycle. A new operation can be accepted every WIDTH+2 cycles.
// Ports:
//   clock  single clock, rising edge
//   rst    synchronous active-low reset
//   bus    slave side of multiplicador_param_if
//          (start, sinal, multiplicando, multiplicador2, produto, Idle, Done)
module multiplicador_param
    import multiplicador_param_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic                  clock,
    input  logic                  rst,
    multiplicador_param_if.slave  bus
);

    localparam int CNT_W = cntWidth(WIDTH);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [2*WIDTH-1:0]  produto_q, produto_d;
    logic                done_q, done_d;

    logic                load;
    logic                step;
    logic                finish;
    logic [2*WIDTH-1:0]  result;

    mult_datapath #(.WIDTH(WIDTH)) datapath (
        .clock    (clock),
        .rst      (rst),
        .load_i   (load),
        .step_i   (step),
        .finish_i (finish),
        .sinal_i  (bus.sinal),
        .opA_i    (bus.multiplicando),
        .opB_i    (bus.multiplicador2),
        .result_o (result)
    );

    // Controller: next state, strobes and counter.
    // finish marks the last CALC step. produto and Done are loaded on that
    // same edge, so Done is a registered pulse that lines up with S_DONE.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                step    = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    finish  = 1'b1;
                    count_d = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        produto_d = finish ? result : produto_q;
        done_d    = finish;
    end

    // Controller and output registers.
    // Reset drops any operation in flight without reporting a result.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            produto_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            produto_q <= produto_d;
            done_q    <= done_d;
        end
    end

    assign bus.produto = produto_q;
    assign bus.Done    = done_q;
    assign bus.Idle    = (state_q == S_IDLE);

endmodule

// File: tb/tb_multiplicador_param.sv
// Self-checking bench for multiplicador_param.
// The main instance is WIDTH=16. WIDTH=4 and WIDTH=32 instances are swept
// with boundary and random vectors against reference products.
module tb_multiplicador_param;

    logic clock = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;
    int overlapViolations = 0;

    // 10 ns clock
    always #5 clock = ~clock;

    multiplicador_param_if #(.WIDTH(16)) bus16 ();
    multiplicador_param_if #(.WIDTH(4))  bus4  ();
    multiplicador_param_if #(.WIDTH(32)) bus32 ();

    multiplicador_param #(.WIDTH(16)) dut16 (.clock(clock), .rst(rst), .bus(bus16));
    multiplicador_param #(.WIDTH(4))  dut4  (.clock(clock), .rst(rst), .bus(bus4));
    multiplicador_param #(.WIDTH(32)) dut32 (.clock(clock), .rst(rst), .bus(bus32));

    typedef struct {
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs [10];

    // Idle and Done must never be high together on any instance
    always @(negedge clock) begin
        if ((bus16.Idle && bus16.Done) || (bus4.Idle && bus4.Done) ||
            (bus32.Idle && bus32.Done))
            overlapViolations++;
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int which, input logic st, input logic sg,
                                 input logic [31:0] a, input logic [31:0] b);
        case (which)
            4: begin
                bus4.start = st; bus4.sinal = sg;
                bus4.multiplicando = a[3:0]; bus4.multiplicador2 = b[3:0];
            end
            32: begin
                bus32.start = st; bus32.sinal = sg;
                bus32.multiplicando = a; bus32.multiplicador2 = b;
            end
            default: begin
                bus16.start = st; bus16.sinal = sg;
                bus16.multiplicando = a[15:0]; bus16.multiplicador2 = b[15:0];
            end
        endcase
    endtask

    function automatic logic [63:0] getProd(input int which);
        case (which)
            4:       return {56'b0, bus4.produto};
            32:      return bus32.produto;
            default: return {32'b0, bus16.produto};
        endcase
    endfunction

    function automatic logic getDone(input int which);
        case (which)
            4:       return bus4.Done;
            32:      return bus32.Done;
            default: return bus16.Done;
        endcase
    endfunction

    function automatic logic getIdle(input int which);
        case (which)
            4:       return bus4.Idle;
            32:      return bus32.Idle;
            default: return bus16.Idle;
        endcase
    endfunction

    // Counts edges until Done is seen, bounded at 200
    task automatic waitDone(input int which, output int edges);
        edges = 0;
        do begin
            @(posedge clock); #1;
            edges++;
        end while (!getDone(which) && edges < 200);
    endtask

    // One isolated operation from IDLE. The latency counts the capture edge.
    task automatic runOp(input int which, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] expected,
                         input string name);
        int edges;
        applyStimulus(which, 1'b1, sg, a, b);
        @(posedge clock); #1;
        applyStimulus(which, 1'b0, sg, a, b);
        waitDone(which, edges);
        checkOutput({name, " latency"}, 64'(edges + 1), 64'(which + 1));
        checkOutput({name, " produto"}, getProd(which), expected);
        @(posedge clock); #1;
    endtask

    initial begin
        int          e;
        logic        doneSeen;
        logic        sg;
        logic [3:0]  a4, b4;
        logic [7:0]  e8;
        logic [31:0] a32, b32;
        logic [63:0] e64;

        vecs[0] = '{1'b0, 16'd2001,  16'd4001,  32'd8006001};
        vecs[1] = '{1'b0, 16'd22,    16'd47,    32'd1034};
        vecs[2] = '{1'b1, 16'hFFFD,  16'd5,     32'hFFFFFFF1};
        vecs[3] = '{1'b1, 16'h8000,  16'h8000,  32'h40000000};
        vecs[4] = '{1'b0, 16'hFFFF,  16'hFFFF,  32'hFFFE0001};
        vecs[5] = '{1'b1, 16'h7FFF,  16'h8000,  32'hC0008000};
        vecs[6] = '{1'b0, 16'd0,     16'd1234,  32'd0};
        vecs[7] = '{1'b1, 16'hFFFF,  16'hFFFF,  32'd1};
        vecs[8] = '{1'b1, 16'hFFFF,  16'd0,     32'd0};
        vecs[9] = '{1'b0, 16'h8000,  16'd2,     32'h00010000};

        rst = 1'b0;
        applyStimulus(16, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(4,  1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(32, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset produto", getProd(16), 64'd0);
        checkOutput("reset Idle",    64'(getIdle(16)), 64'd1);
        checkOutput("reset Done",    64'(getDone(16)), 64'd0);
        checkOutput("reset Idle w4", 64'(getIdle(4)), 64'd1);
        checkOutput("reset Idle w32", 64'(getIdle(32)), 64'd1);
        rst = 1'b1;

        doneSeen = 1'b0;
        repeat (10) begin
            @(posedge clock); #1;
            if (getDone(16)) doneSeen = 1'b1;
        end
        checkOutput("no Done without start", 64'(doneSeen), 64'd0);

        for (int i = 0; i < 10; i++)
            runOp(16, vecs[i].sgn, {16'b0, vecs[i].a}, {16'b0, vecs[i].b},
                  {32'b0, vecs[i].expected}, $sformatf("vec%0d", i));

        // start held high; operands change during CALC and feed the second op
        applyStimulus(16, 1'b1, 1'b0, 32'd2001, 32'd4001);
        @(posedge clock); #1;
        applyStimulus(16, 1'b1, 1'b0, 32'd22, 32'd47);
        waitDone(16, e);
        checkOutput("held first latency", 64'(e + 1), 64'd17);
        checkOutput("held first produto", getProd(16), 64'd8006001);
        waitDone(16, e);
        checkOutput("held spacing", 64'(e), 64'd18);
        checkOutput("held second produto", getProd(16), 64'd1034);
        applyStimulus(16, 1'b0, 1'b0, 32'd22, 32'd47);
        @(posedge clock); #1;
        checkOutput("held back to Idle", 64'(getIdle(16)), 64'd1);

        // a start pulse during CALC is ignored and not queued
        applyStimulus(16, 1'b1, 1'b1, 32'h0000FFFD, 32'd5);
        @(posedge clock); #1;
        applyStimulus(16, 1'b0, 1'b1, 32'h0000FFFD, 32'd5);
        repeat (4) @(posedge clock);
        #1;
        applyStimulus(16, 1'b1, 1'b0, 32'd7, 32'd7);
        @(posedge clock); #1;
        applyStimulus(16, 1'b0, 1'b0, 32'd7, 32'd7);
        waitDone(16, e);
        checkOutput("busy start latency", 64'(e + 6), 64'd17);
        checkOutput("busy start produto", getProd(16), 64'hFFFFFFF1);
        doneSeen = 1'b0;
        repeat (25) begin
            @(posedge clock); #1;
            if (getDone(16)) doneSeen = 1'b1;
        end
        checkOutput("busy start not queued", 64'(doneSeen), 64'd0);

        // reset in the 8th CALC cycle
        applyStimulus(16, 1'b1, 1'b0, 32'h0000FFFF, 32'h0000FFFF);
        @(posedge clock); #1;
        applyStimulus(16, 1'b0, 1'b0, 32'h0000FFFF, 32'h0000FFFF);
        repeat (7) @(posedge clock);
        #1;
        rst = 1'b0;
        @(posedge clock); #1;
        checkOutput("midreset Idle",    64'(getIdle(16)), 64'd1);
        checkOutput("midreset Done",    64'(getDone(16)), 64'd0);
        checkOutput("midreset produto", getProd(16), 64'd0);
        rst = 1'b1;
        doneSeen = 1'b0;
        repeat (20) begin
            @(posedge clock); #1;
            if (getDone(16)) doneSeen = 1'b1;
        end
        checkOutput("midreset no Done", 64'(doneSeen), 64'd0);
        runOp(16, 1'b1, 32'h00008000, 32'h00008000, 64'h40000000, "after reset");

        // WIDTH=4 and WIDTH=32 boundaries
        runOp(4,  1'b1, 32'h8, 32'h8, 64'h40, "w4 minmin");
        runOp(4,  1'b0, 32'hF, 32'hF, 64'hE1, "w4 maxmax");
        runOp(32, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, "w32 minmin");
        runOp(32, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "w32 maxmax");

        // random sweep against reference products
        for (int i = 0; i < 8; i++) begin
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            sg = 1'($urandom_range(0, 1));
            if (sg) e8 = {{4{a4[3]}}, a4} * {{4{b4[3]}}, b4};
            else    e8 = {4'b0, a4} * {4'b0, b4};
            runOp(4, sg, {28'b0, a4}, {28'b0, b4}, {56'b0, e8}, $sformatf("w4 rand%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            a32 = $urandom;
            b32 = $urandom;
            sg  = 1'($urandom_range(0, 1));
            if (sg) e64 = {{32{a32[31]}}, a32} * {{32{b32[31]}}, b32};
            else    e64 = {32'b0, a32} * {32'b0, b32};
            runOp(32, sg, a32, b32, e64, $sformatf("w32 rand%0d", i));
        end

        checkOutput("Idle/Done overlap count", 64'(overlapViolations), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
